// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: fetch FSM states,
// the canonical NOP and the major opcodes consumed by Main_decoder.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC datapath: sequential increment, branch-target mux and the
// word-alignment check on taken branch targets.
module pc_next (
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_new,
    output logic        misalign
);

    assign pc_plus4 = pc + 32'd4;
    assign pc_new   = pc_src ? pc_target : pc_plus4;
    // Only a taken branch can produce a misaligned fetch address.
    assign misalign = pc_src & (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, requests one word per instruction
// and presents it stable to decode until the downstream stage retires it.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IValid,
    input  logic [31:0] IRData,
    output logic [31:0] Instr,
    output logic [6:0]  Op,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        Advance,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        MisalignFault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fault_q, fault_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  pc_new;
    logic         misalign;

    pc_next u_pc_next (
        .pc        (pc_q),
        .pc_src    (PCSrc),
        .pc_target (PCTarget),
        .pc_plus4  (pc_plus4),
        .pc_new    (pc_new),
        .misalign  (misalign)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;

        unique case (state_q)
            FS_IDLE: state_d = FS_FETCH;
            FS_FETCH: begin
                if (IValid) begin
                    instr_d       = IRData;
                    instr_valid_d = 1'b1;
                    state_d       = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (Advance && instr_valid_q) begin
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    if (misalign) begin
                        fault_d = 1'b1;
                        state_d = FS_HALT;
                    end else begin
                        pc_d    = pc_new;
                        state_d = FS_FETCH;
                    end
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    // Every output below depends on registered state only.
    assign IReq          = (state_q == FS_FETCH);
    assign IAddr         = pc_q;
    assign PC            = pc_q;
    assign PCPlus4       = pc_plus4;
    assign Instr         = instr_q;
    assign Op            = instr_q[6:0];
    assign InstrValid    = instr_valid_q;
    assign MisalignFault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch, checked every cycle against
// a behavioural model of the fetch/hold/halt rules.
module tb_instr_fetch;

    logic        clk;
    logic        reset, IValid, Advance, PCSrc;
    logic [31:0] IRData, PCTarget;
    logic        IReq, InstrValid, MisalignFault;
    logic [31:0] IAddr, Instr, PC, PCPlus4;
    logic [6:0]  Op;

    logic        w_reset, w_IValid, w_Advance, w_PCSrc;
    logic [31:0] w_IRData, w_PCTarget;
    logic        w_IReq, w_InstrValid, w_MisalignFault;
    logic [31:0] w_IAddr, w_Instr, w_PC, w_PCPlus4;
    logic [6:0]  w_Op;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase 0=waiting to request, 1=request out,
    // 2=holding an instruction, 3=stopped on fault.
    int          m_phase;
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_fault;

    logic [31:0] words [3];

    instr_fetch dut (
        .clk(clk), .reset(reset), .IReq(IReq), .IAddr(IAddr),
        .IValid(IValid), .IRData(IRData), .Instr(Instr), .Op(Op),
        .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
        .Advance(Advance), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .MisalignFault(MisalignFault)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(w_reset), .IReq(w_IReq), .IAddr(w_IAddr),
        .IValid(w_IValid), .IRData(w_IRData), .Instr(w_Instr), .Op(w_Op),
        .InstrValid(w_InstrValid), .PC(w_PC), .PCPlus4(w_PCPlus4),
        .Advance(w_Advance), .PCSrc(w_PCSrc), .PCTarget(w_PCTarget),
        .MisalignFault(w_MisalignFault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, iv, input logic [31:0] d,
                                input logic a, ps, input logic [31:0] t);
        if (r) begin
            m_phase = 0; m_pc = 32'h0; m_instr = 32'h0000_0013;
            m_valid = 1'b0; m_fault = 1'b0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (iv) begin
                m_instr = d; m_valid = 1'b1; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (a) begin
                m_instr = 32'h0000_0013;
                m_valid = 1'b0;
                if (ps && (t % 4 != 0)) begin
                    m_fault = 1'b1; m_phase = 3;
                end else begin
                    m_pc = ps ? t : m_pc + 32'd4;
                    m_phase = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("IReq",          {31'b0, IReq},          {31'b0, m_phase == 1});
        chk("IAddr",         IAddr,                  m_pc);
        chk("PC",            PC,                     m_pc);
        chk("PCPlus4",       PCPlus4,                m_pc + 32'd4);
        chk("Instr",         Instr,                  m_instr);
        chk("Op",            {25'b0, Op},            {25'b0, m_instr[6:0]});
        chk("InstrValid",    {31'b0, InstrValid},    {31'b0, m_valid});
        chk("MisalignFault", {31'b0, MisalignFault}, {31'b0, m_fault});
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, iv, input logic [31:0] d,
                        input logic a, ps, input logic [31:0] t);
        reset = r; IValid = iv; IRData = d; Advance = a; PCSrc = ps; PCTarget = t;
        model_update(r, iv, d, a, ps, t);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        $display("cyc t=%0t rst=%0b iv=%0b adv=%0b src=%0b tgt=%08h -> ireq=%0b pc=%08h instr=%08h v=%0b f=%0b",
                 $time, r, iv, a, ps, t, IReq, PC, Instr, InstrValid, MisalignFault);
    endtask

    initial begin
        reset = 1'b1; IValid = 1'b0; IRData = '0; Advance = 1'b0; PCSrc = 1'b0; PCTarget = '0;
        w_reset = 1'b1; w_IValid = 1'b0; w_IRData = '0; w_Advance = 1'b0; w_PCSrc = 1'b0; w_PCTarget = '0;
        words[0] = 32'h0020_A023; words[1] = 32'h0020_81B3; words[2] = 32'h0000_0063;
        @(negedge clk);

        // Reset, response two cycles after the request rises.
        step(1, 0, 0, 0, 0, 0);
        chk("rst_ireq", {31'b0, IReq}, 32'd0);
        chk("rst_instr", Instr, 32'h0000_0013);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_iaddr", IAddr, 32'h0);
        chk("t1_ireq", {31'b0, IReq}, 32'd1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_2083, 0, 0, 0);
        chk("t1_valid", {31'b0, InstrValid}, 32'd1);
        chk("t1_op", {25'b0, Op}, 32'b0000011);
        chk("t1_pcp4", PCPlus4, 32'd4);

        // Sequential fetch of three words, 1-cycle latency.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("seq_iaddr", IAddr, 32'(4 * i));
            step(0, 1, words[i], 0, 0, 0);
            chk("seq_op", {25'b0, Op}, {25'b0, words[i][6:0]});
            if (i < 2) step(0, 0, 0, 1, 0, 0);
        end

        // Branch taken from PC 8.
        chk("br_pc", PC, 32'h8);
        step(0, 0, 0, 1, 1, 32'h40);
        chk("br_iaddr", IAddr, 32'h40);

        // Advance during FETCH and IValid during HOLD are ignored.
        step(0, 0, 0, 1, 1, 32'h80);
        chk("ign_adv_pc", PC, 32'h40);
        step(0, 1, 32'h1234_5033, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("ign_iv_instr", Instr, 32'h1234_5033);

        // Misaligned branch halts until reset.
        step(0, 0, 0, 1, 1, 32'h42);
        chk("mis_fault", {31'b0, MisalignFault}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            chk("halt_ireq", {31'b0, IReq}, 32'd0);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("clr_fault", {31'b0, MisalignFault}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("restart_iaddr", IAddr, 32'h0);

        // Reset mid-fetch followed by a stale response in IDLE.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'hBAD0_0003, 0, 0, 0);
        chk("stale_valid", {31'b0, InstrValid}, 32'd0);
        chk("stale_ireq", {31'b0, IReq}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step($urandom_range(60) == 0, $urandom_range(1) == 1, $urandom,
                 $urandom_range(1) == 1, $urandom_range(2) == 0, t);
        end

        // Wrap-around on the second instance.
        @(negedge clk);
        w_reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wrap_iaddr0", w_IAddr, 32'hFFFF_FFFC);
        chk("wrap_pcp4", w_PCPlus4, 32'h0);
        w_IValid = 1'b1; w_IRData = 32'h0000_0013;
        @(posedge clk); @(negedge clk);
        w_IValid = 1'b0;
        chk("wrap_valid", {31'b0, w_InstrValid}, 32'd1);
        w_Advance = 1'b1;
        @(posedge clk); @(negedge clk);
        w_Advance = 1'b0;
        chk("wrap_iaddr", w_IAddr, 32'h0);
        chk("wrap_ireq", {31'b0, w_IReq}, 32'd1);
        $display("wrap: iaddr=%08h ireq=%0b", w_IAddr, w_IReq);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
